// File: rtl/muldiv_div_ctrl.sv
// Execute-stage sequencer for RV32M DIV/DIVU/REM/REMU around a 32-cycle unsigned
// long-division core, with RISC-V special-case results and a one-entry q/r cache.
module muldiv_div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            div_start,
    output logic [XLEN-1:0] div_x,
    output logic [XLEN-1:0] div_y,
    input  logic            div_busy,
    input  logic            div_valid,
    input  logic            div_dbz,
    input  logic [XLEN-1:0] div_q,
    input  logic [XLEN-1:0] div_r
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            sa_q;
    logic            sb_q;

    logic            cache_valid;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic            cache_sgn;
    logic [XLEN-1:0] cache_q;
    logic [XLEN-1:0] cache_r;

    // The core never sees y=0, so its divide-by-zero flag carries no information.
    logic unused_dbz;
    assign unused_dbz = div_dbz;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // sender holds valid and payload stable until that edge.
    assign req_ready = (state == IDLE) && !flush;

    logic            req_sgn;
    logic            req_sa;
    logic            req_sb;
    logic            req_bzero;
    logic            req_ovf;
    logic            req_hit;
    logic [XLEN-1:0] special_data;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] fix_q;
    logic [XLEN-1:0] fix_r;

    always_comb begin
        req_sgn      = !req_op[0];
        req_sa       = req_a[XLEN-1] && req_sgn;
        req_sb       = req_b[XLEN-1] && req_sgn;
        req_bzero    = (req_b == '0);
        req_ovf      = req_sgn && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
        req_hit      = cache_valid && (req_a == cache_a) && (req_b == cache_b)
                       && (req_sgn == cache_sgn);
        special_data = '0;
        if (req_bzero) begin
            special_data = req_op[1] ? req_a : '1;
        end else begin
            special_data = req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        abs_a = req_sa ? (~req_a + 1'b1) : req_a;
        abs_b = req_sb ? (~req_b + 1'b1) : req_b;
        fix_q = (sa_q ^ sb_q) ? (~div_q + 1'b1) : div_q;
        fix_r = sa_q ? (~div_r + 1'b1) : div_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            div_start   <= 1'b0;
            div_x       <= '0;
            div_y       <= '0;
            cache_valid <= 1'b0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_sgn   <= 1'b0;
            cache_q     <= '0;
            cache_r     <= '0;
        end else begin
            div_start <= 1'b0;
            if (flush) begin
                rsp_valid <= 1'b0;
                case (state)
                    START, WAIT, FIX: state <= DRAIN;
                    DONE:             state <= IDLE;
                    DRAIN:            if (!div_busy) state <= IDLE;
                    default:          state <= state;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            op_q <= req_op;
                            a_q  <= req_a;
                            b_q  <= req_b;
                            sa_q <= req_sa;
                            sb_q <= req_sb;
                            if (req_bzero || req_ovf) begin
                                rsp_data  <= special_data;
                                rsp_valid <= 1'b1;
                                state     <= DONE;
                            end else if (req_hit) begin
                                rsp_data  <= req_op[1] ? cache_r : cache_q;
                                rsp_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                div_start <= 1'b1;
                                div_x     <= abs_a;
                                div_y     <= abs_b;
                                state     <= START;
                            end
                        end
                    end
                    // div_valid may still be high from the previous run here.
                    START: state <= WAIT;
                    WAIT: begin
                        if (div_valid) state <= FIX;
                    end
                    FIX: begin
                        cache_valid <= 1'b1;
                        cache_a     <= a_q;
                        cache_b     <= b_q;
                        cache_sgn   <= !op_q[0];
                        cache_q     <= fix_q;
                        cache_r     <= fix_r;
                        rsp_data    <= op_q[1] ? fix_r : fix_q;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end
                    DONE: begin
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    // The start pulse already went out; wait for the core to go idle.
                    DRAIN: begin
                        if (!div_busy) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_div_ctrl.sv
// Directed bench for muldiv_div_ctrl with a behavioural 32-cycle divider core model.
module tb_muldiv_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        div_start;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_busy;
    logic        div_valid;
    logic        div_dbz;
    logic [31:0] div_q;
    logic [31:0] div_r;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    muldiv_div_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .div_start(div_start), .div_x(div_x), .div_y(div_y),
        .div_busy(div_busy), .div_valid(div_valid), .div_dbz(div_dbz),
        .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    // Core model: start sampled at edge S, valid after edge S+32.
    logic [31:0] cx, cy;
    int          ccnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= 1'b0; div_valid <= 1'b0; div_q <= '0; div_r <= '0;
            cx <= '0; cy <= '0; ccnt <= 0;
        end else if (div_start) begin
            div_busy <= 1'b1; div_valid <= 1'b0; ccnt <= 32; cx <= div_x; cy <= div_y;
        end else if (div_busy) begin
            ccnt <= ccnt - 1;
            if (ccnt == 1) begin
                div_busy  <= 1'b0;
                div_valid <= 1'b1;
                div_q     <= (cy == 0) ? 32'hFFFFFFFF : cx / cy;
                div_r     <= (cy == 0) ? cx : cx % cy;
            end
        end
    end
    assign div_dbz = div_valid && (cy == 0);

    always @(posedge clk) begin
        if (rst_n && div_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int exp_starts, input int hold);
        int k, s0, bad;
        logic [31:0] d0;
        k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); k++; end
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        s0 = start_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        check({tag, "_lat"}, 32'(k), 32'(exp_lat));
        check({tag, "_data"}, rsp_data, exp);
        check({tag, "_starts"}, 32'(start_cnt - s0), 32'(exp_starts));
        if (hold > 0) begin
            bad = 0; d0 = rsp_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (rsp_data !== d0 || !rsp_valid || req_ready) bad++;
            end
            check({tag, "_hold"}, 32'(bad), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_vdrop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int k, s0, seen;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0;
        req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_x", div_x, 32'd0);
        check("rst_y", div_y, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 1, 0);
        run_op("remu100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 0, 0, 0);

        run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, 1, 0);
        check("div_m7_2_x", div_x, 32'd7);
        check("div_m7_2_y", div_y, 32'd2);
        run_op("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 0, 0);
        run_op("divu_m7_2", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 35, 1, 0);

        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0, 0);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0, 0, 0);

        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0);
        run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, 0);
        run_op("divu_ovf", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 35, 1, 0);

        run_op("bp_divu", OP_DIVU, 32'd200, 32'd10, 32'd20, 35, 1, 10);

        // Flush ten cycles into a core run.
        req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd81; req_b = 32'd9;
        s0 = start_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        k = 0; seen = 0;
        while (!req_ready && k < 100) begin
            if (rsp_valid) seen++;
            @(negedge clk);
            k++;
        end
        check("fl_drain_len", 32'(k), 32'd24);
        check("fl_busy", 32'(div_busy), 32'd0);
        repeat (5) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        check("fl_no_rsp", 32'(seen), 32'd0);
        check("fl_starts", 32'(start_cnt - s0), 32'd1);

        run_op("remu81_9", OP_REMU, 32'd81, 32'd9, 32'd0, 35, 1, 0);
        run_op("divu81_9_hit", OP_DIVU, 32'd81, 32'd9, 32'd9, 0, 0, 0);

        // Reset in the middle of a core run.
        req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_rspv", 32'(rsp_valid), 32'd0);
        check("mrst_x", div_x, 32'd0);
        check("mrst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("divu81_9_inv", OP_DIVU, 32'd81, 32'd9, 32'd9, 35, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
